pc_seq: RTL and testbench

- Parametrised program-counter sequencer. It is the next generation of the simple 8-bit load-only PC.
- Adds the following on top of a plain PC load:
  - sequential increment;
  - absolute jump;
  - conditional PC-relative branch;
  - call/return through an internal return-address stack (RAS);
  - stall via clock enable.
- Sits between the instruction decoder (which supplies op, target, offset and condition) and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_ras.sv | 98 +++++++++
 rtl/pc_seq.sv | 106 ++++++++++
 tb/tb_pc_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants for the program-counter sequencer: the
//                operation field width and the operation encodings that the
//                instruction decoder presents on the op port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC  = 3'd0;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
    localparam logic [OP_W-1:0] OP_BR   = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL = 3'd3;
    localparam logic [OP_W-1:0] OP_RET  = 3'd4;
    // Encodings 5..7 are reserved and behave as OP_INC.

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack. A push on a full stack either
//                overwrites the oldest entry (OVERWRITE=1) or is dropped
//                (OVERWRITE=0); a pop on an empty stack is ignored. Both cases
//                are reported on overflow/underflow in the same cycle.
//  Ports       : clk, rst (async, active-low)
//                push, push_data   - push request and return address
//                pop               - pop request
//                top               - newest entry (valid when !empty)
//                full, empty       - registered occupancy flags
//                overflow          - push requested while full
//                underflow         - pop requested while empty
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RAS_DEPTH);

    logic [AW-1:0] stack [RAS_DEPTH];
    logic [PW-1:0] ptr;        // next slot to write; ptr-1 is the newest entry
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap so a non-power-of-two depth still cycles through 0..DEPTH-1.
    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PTR_LAST : ptr - 1'b1;

    assign top       = stack[ptr_dec];
    assign overflow  = push & full;
    assign underflow = pop & empty;

    // When full, ptr points at the oldest entry, so a push there is exactly
    // the circular overwrite of the oldest return address.
    assign do_push = push & (~full | OVERWRITE);
    assign do_pop  = pop & ~empty & ~push;

    always_comb begin
        count_nxt = count;
        if (do_push && !full) begin
            count_nxt = count + 1'b1;
        end else if (do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                ptr <= ptr_inc;
            end else if (do_pop) begin
                ptr <= ptr_dec;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_MAX);
            empty <= (count_nxt == '0);
        end
    end

    // Entry contents are don't-care after reset; only the pointer/count matter.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_seq.sv
// ============================================================================
//  Module      : pc_seq
//  Description : Program-counter sequencer with increment, absolute jump,
//                conditional PC-relative branch, call/return through an
//                internal return-address stack, and stall via en.
//                Optional macro PC_RAS_TRAP_EN: a CALL on a full stack or a
//                RET on an empty stack redirects the PC to TRAP_VEC and the
//                overflowing push is dropped instead of overwriting.
//  Ports       : clk, rst (async, active-low)
//                en                  - step enable (0 = hold everything)
//                op                  - INC/JMP/BR/CALL/RET (5..7 = INC)
//                tgt                 - JMP/CALL target
//                br_off, br_take     - BR offset (two's complement) and condition
//                adrs_out            - current PC (register output)
//                ras_full, ras_empty - stack occupancy flags
//                err                 - sticky overflow/underflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq
    import pc_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RST_VEC   = '0,
    parameter logic [AW-1:0] TRAP_VEC  = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [AW-1:0]   tgt,
    input  logic [AW-1:0]   br_off,
    input  logic            br_take,
    output logic [AW-1:0]   adrs_out,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            err
);

`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] ras_top;
    logic          push;
    logic          pop;
    logic          overflow;
    logic          underflow;

    assign pc_inc   = pc + AW'(1);
    assign adrs_out = pc;

    // Stack strobes are gated by en so a stalled CALL/RET never touches it.
    assign push = en & (op == OP_CALL);
    assign pop  = en & (op == OP_RET);

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH),
        .OVERWRITE (!TRAP_EN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pc_inc),
        .pop       (pop),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_JMP:  next_pc = tgt;
            OP_BR:   next_pc = br_take ? pc + br_off : pc_inc;
            OP_CALL: next_pc = (TRAP_EN && overflow) ? TRAP_VEC : tgt;
            OP_RET:  next_pc = underflow ? (TRAP_EN ? TRAP_VEC : pc_inc) : ras_top;
            default: next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= RST_VEC;
            err <= 1'b0;
        end else if (en) begin
            pc <= next_pc;
            if (overflow || underflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_seq.sv
// ============================================================================
//  Module      : tb_pc_seq
//  Description : Self-checking bench for pc_seq (AW=8, RAS_DEPTH=4,
//                RST_VEC=8'h10). Directed scenarios plus random stimulus
//                compared against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq;

    localparam int         DEPTH = 4;
    localparam logic [7:0] RSTV  = 8'h10;
    localparam logic [7:0] TRAPV = 8'hFF;
`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] tgt = 8'h00;
    logic [7:0] br_off = 8'h00;
    logic       br_take = 1'b0;
    logic [7:0] adrs_out;
    logic       ras_full;
    logic       ras_empty;
    logic       err;

    int errors = 0;
    int checks = 0;

    // Behavioural model: PC value, stack as a queue (back = newest), sticky error.
    logic [7:0] m_pc = RSTV;
    logic [7:0] m_ras[$];
    bit         m_err = 1'b0;

    pc_seq #(
        .AW        (8),
        .RAS_DEPTH (DEPTH),
        .RST_VEC   (RSTV),
        .TRAP_VEC  (TRAPV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .tgt       (tgt),
        .br_off    (br_off),
        .br_take   (br_take),
        .adrs_out  (adrs_out),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RSTV;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit e, input logic [2:0] o, input logic [7:0] t,
                              input logic [7:0] off, input bit tk);
        logic [7:0] nx;
        if (!e) return;
        nx = m_pc + 8'd1;
        case (o)
            3'd1: nx = t;
            3'd2: if (tk) nx = m_pc + off;
            3'd3: begin
                if (m_ras.size() == DEPTH) begin
                    m_err = 1'b1;
                    if (TRAP) nx = TRAPV;
                    else begin
                        void'(m_ras.pop_front());
                        m_ras.push_back(m_pc + 8'd1);
                        nx = t;
                    end
                end else begin
                    m_ras.push_back(m_pc + 8'd1);
                    nx = t;
                end
            end
            3'd4: begin
                if (m_ras.size() == 0) begin
                    m_err = 1'b1;
                    if (TRAP) nx = TRAPV;
                end else begin
                    nx = m_ras.pop_back();
                end
            end
            default: ;
        endcase
        m_pc = nx;
    endtask

    // Apply one cycle of stimulus, let the edge happen, advance the model.
    task automatic step(input bit e, input logic [2:0] o, input logic [7:0] t,
                        input logic [7:0] off, input bit tk);
        en = e; op = o; tgt = t; br_off = off; br_take = tk;
        @(posedge clk);
        #1;
        model_step(e, o, t, off, tk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        if (adrs_out !== 8'h10) begin errors++; $display("FAIL reset_pc: got %h want %h", adrs_out, 8'h10); end
        checks++;
        if ({ras_empty, ras_full, err} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b want 100", {ras_empty, ras_full, err}); end
        checks++;
        rst = 1'b1;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        if (adrs_out !== 8'h10) begin errors++; $display("FAIL stall_hold: got %h want %h", adrs_out, 8'h10); end
        checks++;
        // Stalled CALL must not push.
        step(1'b0, 3'd3, 8'h77, 8'h00, 1'b0);
        if ({adrs_out, ras_empty} !== {8'h10, 1'b1}) begin errors++; $display("FAIL stall_call: got %h/%b want 10/1", adrs_out, ras_empty); end
        checks++;
    endtask

    task automatic test_inc_jmp_wrap();
        step(1'b1, 3'd1, 8'hFF, 8'h00, 1'b0);
        step(1'b1, 3'd0, 8'h00, 8'h00, 1'b0);
        if (adrs_out !== 8'h00) begin errors++; $display("FAIL inc_wrap: got %h want %h", adrs_out, 8'h00); end
        checks++;
        step(1'b1, 3'd1, 8'h40, 8'h00, 1'b0);
        if (adrs_out !== 8'h40) begin errors++; $display("FAIL jmp: got %h want %h", adrs_out, 8'h40); end
        checks++;
        step(1'b1, 3'd6, 8'h99, 8'h00, 1'b0);
        if (adrs_out !== 8'h41) begin errors++; $display("FAIL reserved_op: got %h want %h", adrs_out, 8'h41); end
        checks++;
    endtask

    task automatic test_branch();
        step(1'b1, 3'd1, 8'h40, 8'h00, 1'b0);
        step(1'b1, 3'd2, 8'h00, 8'hF0, 1'b1);
        if (adrs_out !== 8'h30) begin errors++; $display("FAIL br_taken: got %h want %h", adrs_out, 8'h30); end
        checks++;
        step(1'b1, 3'd1, 8'h40, 8'h00, 1'b0);
        step(1'b1, 3'd2, 8'h00, 8'hF0, 1'b0);
        if (adrs_out !== 8'h41) begin errors++; $display("FAIL br_not_taken: got %h want %h", adrs_out, 8'h41); end
        checks++;
        step(1'b1, 3'd1, 8'h05, 8'h00, 1'b0);
        step(1'b1, 3'd2, 8'h00, 8'hF0, 1'b1);
        if (adrs_out !== 8'hF5) begin errors++; $display("FAIL br_wrap: got %h want %h", adrs_out, 8'hF5); end
        checks++;
        step(1'b1, 3'd2, 8'h00, 8'h00, 1'b1);
        if (adrs_out !== 8'hF5) begin errors++; $display("FAIL br_selfloop: got %h want %h", adrs_out, 8'hF5); end
        checks++;
    endtask

    task automatic test_nested_call();
        step(1'b1, 3'd1, 8'h20, 8'h00, 1'b0);
        step(1'b1, 3'd3, 8'h80, 8'h00, 1'b0);
        if (adrs_out !== 8'h80) begin errors++; $display("FAIL call1: got %h want %h", adrs_out, 8'h80); end
        checks++;
        step(1'b1, 3'd3, 8'h90, 8'h00, 1'b0);
        if (adrs_out !== 8'h90) begin errors++; $display("FAIL call2: got %h want %h", adrs_out, 8'h90); end
        checks++;
        step(1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
        if (adrs_out !== 8'h81) begin errors++; $display("FAIL ret1: got %h want %h", adrs_out, 8'h81); end
        checks++;
        step(1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
        if (adrs_out !== 8'h21) begin errors++; $display("FAIL ret2: got %h want %h", adrs_out, 8'h21); end
        checks++;
        if ({ras_empty, err} !== 2'b10) begin errors++; $display("FAIL nest_end_flags: got %b want 10", {ras_empty, err}); end
        checks++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ret[5];
        step(1'b1, 3'd1, 8'h00, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 3'd3, 8'(i * 16), 8'h00, 1'b0);
        if ({ras_full, ras_empty, err} !== 3'b100) begin errors++; $display("FAIL ovf_full4: got %b want 100", {ras_full, ras_empty, err}); end
        checks++;
        step(1'b1, 3'd3, 8'h50, 8'h00, 1'b0);
        if ({adrs_out, ras_full, err} !== {(TRAP ? TRAPV : 8'h50), 2'b11}) begin
            errors++; $display("FAIL ovf_call5: got %h/%b/%b want %h/1/1", adrs_out, ras_full, err, TRAP ? TRAPV : 8'h50);
        end
        checks++;
        // Pushed return addresses were 01,11,21,31 then 41 (dropped under trap).
        if (TRAP) exp_ret = '{8'h31, 8'h21, 8'h11, 8'h01, TRAPV};
        else      exp_ret = '{8'h41, 8'h31, 8'h21, 8'h11, 8'h12};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
            if (adrs_out !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %h want %h", i, adrs_out, exp_ret[i]); end
            checks++;
        end
        if ({ras_empty, ras_full, err} !== 3'b101) begin errors++; $display("FAIL unf_flags: got %b want 101", {ras_empty, ras_full, err}); end
        checks++;
    endtask

    task automatic test_reset_mid_stack();
        // err is already set from the underflow, so the reset clearing it is observable.
        step(1'b1, 3'd3, 8'hA0, 8'h00, 1'b0);
        step(1'b1, 3'd3, 8'hB0, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        if ({adrs_out, ras_empty, ras_full, err} !== {8'h10, 3'b100}) begin
            errors++; $display("FAIL reset_async: got %h/%b%b%b want 10/100", adrs_out, ras_empty, ras_full, err);
        end
        checks++;
        #1;
        rst = 1'b1;
        step(1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
        if ({adrs_out, err} !== {(TRAP ? TRAPV : 8'h11), 1'b1}) begin
            errors++; $display("FAIL reset_no_stale: got %h/%b want %h/1", adrs_out, err, TRAP ? TRAPV : 8'h11);
        end
        checks++;
    endtask

    task automatic test_random();
        // Start from a clean state so the model and DUT agree on the stack.
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), 1'($urandom));
            if ({adrs_out, ras_full, ras_empty, err} !==
                {m_pc, m_ras.size() == DEPTH, m_ras.size() == 0, m_err}) begin
                errors++;
                $display("FAIL random[%0d]: got pc=%h f=%b e=%b err=%b want pc=%h f=%b e=%b err=%b",
                         i, adrs_out, ras_full, ras_empty, err,
                         m_pc, m_ras.size() == DEPTH, m_ras.size() == 0, m_err);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_inc_jmp_wrap();
        test_branch();
        test_nested_call();
        test_overflow();
        test_reset_mid_stack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
